// File: rtl/beam_direction_decoder_if.sv
// Doorway beam interface: raw beam-break inputs in, direction/abort pulses and fault level out.
// master drives the beams and observes the decoder; slave is the decoder itself.
interface beam_direction_decoder_if;
    logic beam_a;
    logic beam_b;
    logic entry_sensor;
    logic exit_sensor;
    logic abort_pulse;
    logic beam_fault;

    modport master (
        output beam_a, beam_b,
        input  entry_sensor, exit_sensor, abort_pulse, beam_fault
    );

    modport slave (
        input  beam_a, beam_b,
        output entry_sensor, exit_sensor, abort_pulse, beam_fault
    );
endinterface

// File: rtl/beam_direction_decoder.sv
// Purpose: sync + debounce two IR beams, ordered-sequence FSM emits entry/exit/abort pulses (stuck detector under BEAM_STUCK_DETECT_EN).
// Latency: raw beam to filtered 2+DEBOUNCE_CYCLES cycles, filtered to registered pulse 1 cycle.
// Backpressure: none; pulses are single-cycle and must be consumed by the downstream counter.
module beam_direction_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int STUCK_CYCLES    = 5000
) (
    input logic                      clk,
    input logic                      rst,
    beam_direction_decoder_if.slave  bus
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A} state_t;

    logic [1:0]    raw, sync1, sync2, filt;
    logic [DW-1:0] db_cnt [2];

    assign raw = {bus.beam_b, bus.beam_a};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            filt  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic fa, fb, a_only, b_only, both, clear;
    assign fa     = filt[0];
    assign fb     = filt[1];
    assign a_only = fa & ~fb;
    assign b_only = ~fa & fb;
    assign both   = fa & fb;
    assign clear  = ~fa & ~fb;

    state_t        state, nxt;
    logic          go_entry, go_exit, go_abort;
    logic [TW-1:0] to_cnt;
    logic          fault_block;
    logic          entry_q, exit_q, abort_q;

    always_comb begin
        nxt      = state;
        go_entry = 1'b0;
        go_exit  = 1'b0;
        go_abort = 1'b0;
        case (state)
            IDLE: begin
                if (a_only)      nxt = IN_A;
                else if (b_only) nxt = OUT_B;
            end
            IN_A: begin
                if (both)        nxt = IN_AB;
                else if (b_only) nxt = IN_B;
                else if (clear)  begin nxt = IDLE; go_abort = 1'b1; end
            end
            IN_AB: begin
                if (b_only)      nxt = IN_B;
                else if (a_only) nxt = IN_A;
                else if (clear)  begin nxt = IDLE; go_abort = 1'b1; end
            end
            IN_B: begin
                if (clear)       begin nxt = IDLE; go_entry = 1'b1; end
                else if (both)   nxt = IN_AB;
                else if (a_only) begin nxt = IDLE; go_abort = 1'b1; end
            end
            OUT_B: begin
                if (both)        nxt = OUT_AB;
                else if (a_only) nxt = OUT_A;
                else if (clear)  begin nxt = IDLE; go_abort = 1'b1; end
            end
            OUT_AB: begin
                if (a_only)      nxt = OUT_A;
                else if (b_only) nxt = OUT_B;
                else if (clear)  begin nxt = IDLE; go_abort = 1'b1; end
            end
            OUT_A: begin
                if (clear)       begin nxt = IDLE; go_exit = 1'b1; end
                else if (both)   nxt = OUT_AB;
                else if (b_only) begin nxt = IDLE; go_abort = 1'b1; end
            end
            default: nxt = IDLE;
        endcase
        // A stalled passage gives up only if nothing else moved it this cycle.
        if (state != IDLE && nxt == state && to_cnt == TO_LAST) begin
            nxt      = IDLE;
            go_abort = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            to_cnt  <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            abort_q <= 1'b0;
        end else if (fault_block) begin
            state   <= IDLE;
            to_cnt  <= '0;
            entry_q <= 1'b0;
            exit_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state   <= nxt;
            to_cnt  <= (state == IDLE || nxt != state) ? '0 : to_cnt + 1'b1;
            entry_q <= go_entry;
            exit_q  <= go_exit;
            abort_q <= go_abort;
        end
    end

    assign bus.entry_sensor = entry_q;
    assign bus.exit_sensor  = exit_q;
    assign bus.abort_pulse  = abort_q;

`ifdef BEAM_STUCK_DETECT_EN
    localparam int SW = $clog2(STUCK_CYCLES + 1);
    localparam logic [SW-1:0] ST_LAST = SW'(STUCK_CYCLES - 1);
    localparam logic [SW-1:0] ST_FULL = SW'(STUCK_CYCLES);

    logic [SW-1:0] stuck_cnt [2];
    logic          fault_q;
    logic          stuck_trip;

    assign stuck_trip = (filt[0] && stuck_cnt[0] == ST_LAST) ||
                        (filt[1] && stuck_cnt[1] == ST_LAST);

    // Counters saturate so a beam held past the threshold trips exactly once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) stuck_cnt[i] <= '0;
            fault_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (!filt[i])                    stuck_cnt[i] <= '0;
                else if (stuck_cnt[i] != ST_FULL) stuck_cnt[i] <= stuck_cnt[i] + 1'b1;
            end
            if (stuck_trip)         fault_q <= 1'b1;
            else if (filt == 2'b00) fault_q <= 1'b0;
        end
    end

    assign fault_block    = fault_q | stuck_trip;
    assign bus.beam_fault = fault_q;
`else
    assign fault_block    = 1'b0;
    // Detector compiled out: constant low that keeps the threshold parameter referenced.
    assign bus.beam_fault = (STUCK_CYCLES < 0);
`endif
endmodule

// File: tb/tb_beam_direction_decoder.sv
// Bench for beam_direction_decoder: directed doorway scenarios plus random beam patterns against a path-position model.
module tb_beam_direction_decoder;
    localparam int D = 4;
    localparam int T = 50;
    localparam int S = 200;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    beam_direction_decoder_if bus();

    beam_direction_decoder #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T),
        .STUCK_CYCLES   (S)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: raw history windows, filtered beams, and passage as (direction, position along path).
    bit qa[$];
    bit qb[$];
    bit mfa, mfb;
    int dir, pos, still, run_a, run_b;
    bit m_fault, m_entry, m_exit, m_abort;

    function automatic logic [3:0] outs();
        return {bus.entry_sensor, bus.exit_sensor, bus.abort_pulse, bus.beam_fault};
    endfunction

    function automatic logic [3:0] expv();
        return {m_entry, m_exit, m_abort, m_fault};
    endfunction

    // Position of a beam pattern along a path: 0 clear, 1 first beam, 2 both, 3 second beam only.
    function automatic int pat(int d, bit fa, bit fb);
        if (!fa && !fb) return 0;
        if (fa && fb)   return 2;
        if (d == 1)     return fa ? 1 : 3;
        return fb ? 1 : 3;
    endfunction

    // Filtered value flips once the last D synced samples all disagree with it.
    function automatic bit flips(bit q[$], bit f);
        for (int j = 0; j < D; j++)
            if (q[q.size() - 2 - j] == f) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        repeat (D + 1) begin
            qa.push_back(1'b0);
            qb.push_back(1'b0);
        end
        mfa = 0; mfb = 0; dir = 0; pos = 0; still = 0; run_a = 0; run_b = 0;
        m_fault = 0; m_entry = 0; m_exit = 0; m_abort = 0;
    endtask

    task automatic model_step(input bit a, input bit b);
        bit trip;
        bit blk;
        bit na, nb;
        int p;
        m_entry = 0; m_exit = 0; m_abort = 0;
        trip = 0;
`ifdef BEAM_STUCK_DETECT_EN
        trip  = (mfa && run_a == S - 1) || (mfb && run_b == S - 1);
        run_a = mfa ? ((run_a < S) ? run_a + 1 : S) : 0;
        run_b = mfb ? ((run_b < S) ? run_b + 1 : S) : 0;
        blk   = m_fault || trip;
        if (trip)              m_fault = 1;
        else if (!mfa && !mfb) m_fault = 0;
`else
        blk = trip;
`endif
        if (blk) begin
            dir = 0;
        end else if (dir == 0) begin
            still = 0;
            if (mfa && !mfb)      begin dir = 1; pos = 1; end
            else if (!mfa && mfb) begin dir = 2; pos = 1; end
        end else begin
            p = pat(dir, mfa, mfb);
            if (p == pos) begin
                still++;
                if (still == T) begin m_abort = 1; dir = 0; end
            end else if (p == 0) begin
                if (pos == 3) begin
                    if (dir == 1) m_entry = 1;
                    else          m_exit  = 1;
                end else begin
                    m_abort = 1;
                end
                dir = 0;
            end else if (pos == 3 && p == 1) begin
                m_abort = 1;
                dir = 0;
            end else begin
                pos = p;
                still = 0;
            end
        end
        na = flips(qa, mfa) ? !mfa : mfa;
        nb = flips(qb, mfb) ? !mfb : mfb;
        mfa = na;
        mfb = nb;
        qa.push_back(a); void'(qa.pop_front());
        qb.push_back(b); void'(qb.pop_front());
    endtask

    task automatic tick(input bit a, input bit b);
        bus.beam_a = a;
        bus.beam_b = b;
        @(posedge clk);
        model_step(a, b);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        bus.beam_a = 1'b0;
        bus.beam_b = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (bus.entry_sensor !== 1'b0) begin n_fail++; $display("FAIL reset_entry got=%b want=0", bus.entry_sensor); end
        n_checks++; if (bus.exit_sensor !== 1'b0)  begin n_fail++; $display("FAIL reset_exit got=%b want=0", bus.exit_sensor); end
        n_checks++; if (bus.abort_pulse !== 1'b0)  begin n_fail++; $display("FAIL reset_abort got=%b want=0", bus.abort_pulse); end
        n_checks++; if (bus.beam_fault !== 1'b0)   begin n_fail++; $display("FAIL reset_fault got=%b want=0", bus.beam_fault); end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (outs() !== expv()) begin n_fail++; $display("FAIL reset_idle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
        end
    endtask

    task automatic test_glitch();
        bit [1:0] pt [4] = '{2'b01, 2'b00, 2'b01, 2'b00};
        int       ln [4] = '{3, 20, 20, 20};
        int npulse = 0;
        int at = -1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= ln[p]; i++) begin
                tick(pt[p][0], pt[p][1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL glitch_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                if (p < 2 && outs() != 4'b0) npulse++;
                if (p == 3 && bus.abort_pulse) at = i;
            end
        end
        n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL glitch_no_pulse got=%0d want=0", npulse); end
        n_checks++; if (at !== 2 + D + 1) begin n_fail++; $display("FAIL long_a_abort_at got=%0d want=%0d", at, 2 + D + 1); end
    endtask

    task automatic test_inward();
        bit [1:0] pt [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
        int ne = 0, nx = 0, na = 0, at = -1;
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= 20; i++) begin
                tick(pt[p][0], pt[p][1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL inward_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                if (bus.entry_sensor) ne++;
                if (bus.exit_sensor)  nx++;
                if (bus.abort_pulse)  na++;
                if (p == 3 && bus.entry_sensor) at = i;
            end
        end
        n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL inward_entry_count got=%0d want=1", ne); end
        n_checks++; if (nx !== 0) begin n_fail++; $display("FAIL inward_exit_count got=%0d want=0", nx); end
        n_checks++; if (na !== 0) begin n_fail++; $display("FAIL inward_abort_count got=%0d want=0", na); end
        n_checks++; if (at !== 2 + D + 1) begin n_fail++; $display("FAIL inward_entry_at got=%0d want=%0d", at, 2 + D + 1); end
    endtask

    task automatic test_outward_b2b();
        bit [1:0] pt [8] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        int       ln [8] = '{20, 20, 20, 10, 15, 15, 15, 20};
        int ne = 0, nx = 0, na = 0;
        for (int p = 0; p < 8; p++) begin
            for (int i = 1; i <= ln[p]; i++) begin
                tick(pt[p][0], pt[p][1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL outward_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                if (bus.entry_sensor) ne++;
                if (bus.exit_sensor)  nx++;
                if (bus.abort_pulse)  na++;
            end
        end
        n_checks++; if (nx !== 2) begin n_fail++; $display("FAIL outward_exit_count got=%0d want=2", nx); end
        n_checks++; if (ne + na !== 0) begin n_fail++; $display("FAIL outward_other_pulses got=%0d want=0", ne + na); end
    endtask

    task automatic test_backout();
        bit [1:0] pt [4] = '{2'b01, 2'b11, 2'b01, 2'b00};
        int ne = 0, na = 0;
        for (int p = 0; p < 4; p++) begin
            for (int i = 1; i <= 20; i++) begin
                tick(pt[p][0], pt[p][1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL backout_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                if (bus.entry_sensor) ne++;
                if (bus.abort_pulse)  na++;
            end
        end
        n_checks++; if (na !== 1) begin n_fail++; $display("FAIL backout_abort_count got=%0d want=1", na); end
        n_checks++; if (ne !== 0) begin n_fail++; $display("FAIL backout_entry_count got=%0d want=0", ne); end
    endtask

    task automatic test_timeout();
        int na = 0, first = -1;
        for (int i = 1; i <= 120; i++) begin
            tick(i <= 100, 1'b0);
            n_checks++;
            if (outs() !== expv()) begin n_fail++; $display("FAIL timeout_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
            if (bus.abort_pulse) begin
                na++;
                if (first < 0) first = i;
            end
        end
        n_checks++; if (first !== 2 + D + 1 + T) begin n_fail++; $display("FAIL timeout_abort_at got=%0d want=%0d", first, 2 + D + 1 + T); end
        n_checks++; if (na !== 2) begin n_fail++; $display("FAIL timeout_abort_count got=%0d want=2", na); end
    endtask

    task automatic test_reset_mid();
        int npulse = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, i >= 20);
            n_checks++;
            if (outs() !== expv()) begin n_fail++; $display("FAIL midreset_pre cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
        end
        rst = 1'b0;
        #1;
        n_checks++; if (outs() !== 4'b0) begin n_fail++; $display("FAIL midreset_outputs got=%b want=0000", outs()); end
        repeat (3) @(negedge clk);
        n_checks++; if (outs() !== 4'b0) begin n_fail++; $display("FAIL midreset_held got=%b want=0000", outs()); end
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            tick(i < 20, i < 20);
            n_checks++;
            if (outs() !== expv()) begin n_fail++; $display("FAIL midreset_post cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
            if (outs() != 4'b0) npulse++;
        end
        n_checks++; if (npulse !== 0) begin n_fail++; $display("FAIL midreset_no_pulse got=%0d want=0", npulse); end
    endtask

    task automatic test_stuck();
        bit [1:0] pt [6] = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        int       ln [6] = '{300, 30, 20, 20, 20, 20};
        int first = -1, during = 0, ne = 0;
`ifdef BEAM_STUCK_DETECT_EN
        int want_first = 2 + D + S;
`else
        int want_first = -1;
`endif
        for (int p = 0; p < 6; p++) begin
            for (int i = 1; i <= ln[p]; i++) begin
                tick(pt[p][0], pt[p][1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL stuck_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                if (p == 0 && bus.beam_fault && first < 0) first = i;
                if (bus.beam_fault && (bus.entry_sensor || bus.exit_sensor || bus.abort_pulse)) during++;
                if (p >= 2 && bus.entry_sensor) ne++;
            end
        end
        n_checks++; if (first !== want_first) begin n_fail++; $display("FAIL stuck_fault_at got=%0d want=%0d", first, want_first); end
        n_checks++; if (during !== 0) begin n_fail++; $display("FAIL stuck_pulse_in_fault got=%0d want=0", during); end
        n_checks++; if (bus.beam_fault !== 1'b0) begin n_fail++; $display("FAIL stuck_fault_cleared got=%b want=0", bus.beam_fault); end
        n_checks++; if (ne !== 1) begin n_fail++; $display("FAIL stuck_entry_after got=%0d want=1", ne); end
    endtask

    task automatic test_random();
        bit [1:0] pt;
        int len;
        for (int p = 0; p < 50; p++) begin
            pt  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 70);
            for (int i = 0; i < len; i++) begin
                tick(pt[0], pt[1]);
                n_checks++;
                if (outs() !== expv()) begin n_fail++; $display("FAIL random_cycle cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
                n_checks++;
                if (int'(bus.entry_sensor) + int'(bus.exit_sensor) + int'(bus.abort_pulse) > 1) begin
                    n_fail++;
                    $display("FAIL random_exclusive cyc=%0d got=%b want=at_most_one", cyc, outs());
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0);
            n_checks++;
            if (outs() !== expv()) begin n_fail++; $display("FAIL random_drain cyc=%0d dut=%b model=%b", cyc, outs(), expv()); end
        end
    endtask

    initial begin
        bus.beam_a = 1'b0;
        bus.beam_b = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_inward();
        test_outward_b2b();
        test_backout();
        test_timeout();
        test_reset_mid();
        test_stuck();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/beam_direction_decoder.md
Name: beam_direction_decoder

Overview:
- Front-end for occupancy_tracker: turns two raw IR beam-break inputs at the doorway into one-cycle entry_sensor / exit_sensor pulses.
- beam_a is the outer beam and beam_b the inner beam.
- Input path: synchronise, debounce, then an ordered-sequence FSM decides direction. Partial or aborted passages produce no count.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples needed before a filtered beam changes (must be >=1).
- TIMEOUT_CYCLES, 1000: cycles allowed in any non-IDLE state without a state change before abandoning the passage.
- STUCK_CYCLES, 5000: continuous-broken threshold for the fault detector (optional feature only).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- beam_a  in  1  raw outer beam, 1 = broken, asynchronous to clk.
- beam_b  in  1  raw inner beam, 1 = broken, asynchronous to clk.
- entry_sensor  out  1  one-cycle pulse per completed inward passage.
- exit_sensor  out  1  one-cycle pulse per completed outward passage.
- abort_pulse  out  1  one-cycle pulse when a passage is abandoned.
- beam_fault  out  1  level, stuck beam detected (optional feature; otherwise 0).

Behaviour:
- Reset (rst low, asynchronous): all outputs 0; sync flops, filtered beams and counters 0; FSM in IDLE.
- Synchroniser: two flops per beam.
- Debounce, per beam:
  - The counter clears whenever the synced value equals the filtered value.
  - Otherwise the counter increments. When the count reaches DEBOUNCE_CYCLES, the filtered value takes the synced value and the counter clears.
  - Raw-to-filtered latency = 2 + DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES synced cycles are ignored.
- FSM on the filtered pair (fa, fb). States: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_AB, OUT_A.
- IDLE:
  - fa&!fb goes to IN_A.
  - !fa&fb goes to OUT_B.
  - fa&fb stays in IDLE (ambiguous start, wait for clear).
- Inward path:
  - IN_A: fa&fb goes to IN_AB; !fa&fb goes to IN_B; !fa&!fb goes to IDLE with abort.
  - IN_AB: !fa&fb goes to IN_B; fa&!fb goes to IN_A (backed off); !fa&!fb goes to IDLE with abort.
  - IN_B: !fa&!fb goes to IDLE and pulses entry_sensor; fa&fb goes to IN_AB; fa&!fb goes to IDLE with abort.
- Outward path: mirror image of the inward path with a and b swapped. Completion from OUT_A pulses exit_sensor.
- Pulse timing: pulses are registered, high for exactly the one cycle following the clock edge on which the FSM takes the completing or aborting transition. They are never asserted together.
- Timeout counter:
  - Clears on every state change and while in IDLE.
  - When it reaches TIMEOUT_CYCLES in a non-IDLE state, the FSM goes to IDLE and abort_pulse is raised.
  - After a timeout the FSM re-enters a path only from IDLE rules. A beam still broken with the other clear starts a new path on the next cycle.
- Back-to-back passages: a new sequence may start the cycle after IDLE is re-entered. No dead time is required.
- Reset mid-passage: the passage is discarded, no pulse is produced, and the FSM restarts in IDLE.

Optional Feature:
- Macro: BEAM_STUCK_DETECT_EN.
- Defined:
  - A per-beam counter counts consecutive cycles with the filtered beam broken.
  - At STUCK_CYCLES, beam_fault sets and the FSM is forced to IDLE. No abort pulse is raised for this forced return.
  - While beam_fault=1, no pulses are produced.
  - beam_fault clears one cycle after both filtered beams read clear.
- Undefined: no stuck counters; beam_fault is tied to 0.

Test Plan:
- DEBOUNCE_CYCLES=4: raise beam_a for 3 cycles, then drop it -> filtered fa never changes, no pulses. Raise it for 20 cycles -> fa rises 6 cycles after the raw edge.
- Inward sequence A, then AB, then B, then clear, each phase 20 cycles -> exactly one entry_sensor pulse, 1 cycle wide, about 6 cycles after beam_b clears; exit_sensor and abort_pulse stay 0.
- Outward sequence B, then AB, then A, then clear -> exactly one exit_sensor pulse. Two outward passages back-to-back -> two pulses.
- Inward sequence A, then AB, then A, then clear (person backs out) -> one abort_pulse, no entry_sensor.
- TIMEOUT_CYCLES=50: hold A only for 100 cycles -> abort_pulse 50 cycles after entering IN_A, then IN_A re-entered on the next cycle. Assert rst during IN_AB -> all outputs 0 and no pulse after release.
- With BEAM_STUCK_DETECT_EN and STUCK_CYCLES=200: hold beam_b for 300 cycles -> beam_fault=1 at cycle 200 with no pulses; clear both beams -> beam_fault=0, and the next full inward sequence counts normally.
